// File: rtl/wm_access_arbiter.sv
// ---------------------------------------------------------------------------
// wm_access_arbiter
//
// Shares one working-memory (WM) read port and one WM write port among NREQ
// requesters (relax engine, output walker, refresh/init sequencer). One
// access, read or write, is granted per cycle in round-robin order. Read
// data comes back to the requester that issued it after a fixed pipeline
// latency, marked by a one-hot strobe. A flush request stops new grants and
// lets every in-flight read finish before an iteration boundary.
//
// Optional feature macro: WM_RAW_BYPASS_EN
//   defined   : each read in flight also records its address. A write granted
//               while a read of the same address is still in flight replaces
//               the data that read returns. The newest write wins.
//   undefined : no address comparators. A read returns the WM contents as
//               they were in its issue cycle.
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-low reset
//   req_valid   per-requester request present
//   req_we      per-requester 1 = write, 0 = read
//   req_addr    packed addresses, requester i at [i*AW +: AW]
//   req_wdata   packed write data, requester i at [i*DW +: DW]
//   req_ready   one-hot grant, combinational; consumed when valid & ready
//   rsp_valid   one-hot read-data strobe
//   rsp_data    read data, holds its last value between strobes
//   flush       stop granting and drain outstanding reads
//   flush_done  high while drained and flush is still held
//   WMAR        WM read address
//   WMDR        WM read data (RD_LAT cycles after the grant cycle)
//   WMWAR       WM write address
//   WMWDR       WM write data
//   WMWE        WM write enable
// ---------------------------------------------------------------------------
module wm_access_arbiter #(
  parameter int NREQ   = 3,
  parameter int AW     = 13,
  parameter int DW     = 128,
  parameter int RD_LAT = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  input  logic               flush,
  output logic               flush_done,
  output logic [AW-1:0]      WMAR,
  input  logic [DW-1:0]      WMDR,
  output logic [AW-1:0]      WMWAR,
  output logic [DW-1:0]      WMWDR,
  output logic               WMWE
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t            state_q;
  logic              flushDone_q;
  logic [PW-1:0]     rrPtr_q;
  logic [PW-1:0]     rrPtr_d;

  logic [PW:0]       candSum;
  logic              grantFound;
  logic [PW-1:0]     grantIdx;
  logic [NREQ-1:0]   grantVec;
  logic              selWe;
  logic [AW-1:0]     selAddr;
  logic [DW-1:0]     selWdata;
  logic              rdGrant;
  logic              wrGrant;

  logic [AW-1:0]     wmAddr_q;
  logic [AW-1:0]     wmWAddr_q;
  logic [DW-1:0]     wmWData_q;
  logic              wmWe_q;
  logic [NREQ-1:0]   rspValid_q;
  logic [DW-1:0]     rspData_q;

  // Tag pipeline: one stage per cycle of read latency. The last stage lines
  // up with the cycle in which WMDR carries that read's data.
  logic [RD_LAT-1:0] stgValid_q;
  logic [PW-1:0]     stgIdx_q [RD_LAT];

`ifdef WM_RAW_BYPASS_EN
  logic [AW-1:0]     stgAddr_q  [RD_LAT];
  logic [RD_LAT-1:0] stgByp_q;
  logic [DW-1:0]     stgBdata_q [RD_LAT];
  logic [RD_LAT-1:0] bypFlag_c;
  logic [DW-1:0]     bypData_c  [RD_LAT];
`endif

  // Round-robin search: first valid requester at or after the pointer,
  // wrapping. The sum never reaches 2*NREQ, so one subtraction wraps it.
  always_comb begin
    candSum    = '0;
    grantFound = 1'b0;
    grantIdx   = '0;
    grantVec   = '0;
    if (reset && (state_q == RUN) && !flush) begin
      for (int k = 0; k < NREQ; k++) begin
        candSum = {1'b0, rrPtr_q} + (PW+1)'(k);
        if (candSum >= (PW+1)'(NREQ)) begin
          candSum = candSum - (PW+1)'(NREQ);
        end
        if (!grantFound && req_valid[candSum[PW-1:0]]) begin
          grantFound = 1'b1;
          grantIdx   = candSum[PW-1:0];
        end
      end
      if (grantFound) begin
        grantVec[grantIdx] = 1'b1;
      end
    end
  end

  assign selWe    = req_we[grantIdx];
  assign selAddr  = req_addr[int'(grantIdx)*AW +: AW];
  assign selWdata = req_wdata[int'(grantIdx)*DW +: DW];
  assign rdGrant  = grantFound & ~selWe;
  assign wrGrant  = grantFound & selWe;
  assign rrPtr_d  = (grantIdx == PW'(NREQ-1)) ? '0 : grantIdx + 1'b1;

`ifdef WM_RAW_BYPASS_EN
  // A write granted now overrides the data of every in-flight read of the
  // same address; a later write simply overwrites an earlier capture.
  always_comb begin
    bypFlag_c = stgByp_q;
    bypData_c = stgBdata_q;
    for (int s = 0; s < RD_LAT; s++) begin
      if (wrGrant && stgValid_q[s] && (stgAddr_q[s] == selAddr)) begin
        bypFlag_c[s] = 1'b1;
        bypData_c[s] = selWdata;
      end
    end
  end
`endif

  // Datapath: pointer, WM port registers, tag pipeline and response capture.
  // Reset empties the pipeline so reads in flight are never strobed.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rrPtr_q    <= '0;
      wmAddr_q   <= '0;
      wmWAddr_q  <= '0;
      wmWData_q  <= '0;
      wmWe_q     <= 1'b0;
      stgValid_q <= '0;
      rspValid_q <= '0;
      rspData_q  <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        stgIdx_q[s] <= '0;
      end
`ifdef WM_RAW_BYPASS_EN
      stgByp_q <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        stgAddr_q[s]  <= '0;
        stgBdata_q[s] <= '0;
      end
`endif
    end else begin
      if (grantFound) begin
        rrPtr_q <= rrPtr_d;
      end
      wmWe_q <= wrGrant;
      if (wrGrant) begin
        wmWAddr_q <= selAddr;
        wmWData_q <= selWdata;
      end
      if (rdGrant) begin
        wmAddr_q <= selAddr;
      end

      stgValid_q[0] <= rdGrant;
      stgIdx_q[0]   <= grantIdx;
      for (int s = 1; s < RD_LAT; s++) begin
        stgValid_q[s] <= stgValid_q[s-1];
        stgIdx_q[s]   <= stgIdx_q[s-1];
      end

      rspValid_q <= '0;
      if (stgValid_q[RD_LAT-1]) begin
        rspValid_q[stgIdx_q[RD_LAT-1]] <= 1'b1;
`ifdef WM_RAW_BYPASS_EN
        rspData_q <= bypFlag_c[RD_LAT-1] ? bypData_c[RD_LAT-1] : WMDR;
`else
        rspData_q <= WMDR;
`endif
      end

`ifdef WM_RAW_BYPASS_EN
      stgAddr_q[0]  <= selAddr;
      stgByp_q[0]   <= 1'b0;
      stgBdata_q[0] <= '0;
      for (int s = 1; s < RD_LAT; s++) begin
        stgAddr_q[s]  <= stgAddr_q[s-1];
        stgByp_q[s]   <= bypFlag_c[s-1];
        stgBdata_q[s] <= bypData_c[s-1];
      end
`endif
    end
  end

  // Flush control. The grant is already blocked combinationally in the
  // cycle flush rises. DRAIN waits for an empty tag pipeline; the final
  // response is still in the output register then, so flush_done rises the
  // cycle after the last strobe.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= RUN;
      flushDone_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (flush) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (stgValid_q == '0) begin
            if (flush) begin
              state_q     <= DONE;
              flushDone_q <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        DONE: begin
          if (!flush) begin
            state_q     <= RUN;
            flushDone_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= RUN;
          flushDone_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = grantVec;
  assign rsp_valid  = rspValid_q;
  assign rsp_data   = rspData_q;
  assign flush_done = flushDone_q;
  assign WMAR       = wmAddr_q;
  assign WMWAR      = wmWAddr_q;
  assign WMWDR      = wmWData_q;
  assign WMWE       = wmWe_q;

endmodule

// File: tb/tb_wm_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wm_access_arbiter
//
// Drives wm_access_arbiter against a behavioural WM (one-cycle synchronous
// read, writes visible on the following cycle) and compares every output,
// every cycle, with a transaction-level reference model: a round-robin
// pointer, a flat memory image updated at grant time, and a queue of
// expected responses each stamped with the cycle it is due.
// ---------------------------------------------------------------------------
module tb_wm_access_arbiter;

  localparam int NREQ   = 3;
  localparam int AW     = 13;
  localparam int DW     = 128;
  localparam int RD_LAT = 2;

  logic               clock;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               flush;
  logic               flush_done;
  logic [AW-1:0]      WMAR;
  logic [DW-1:0]      WMDR;
  logic [AW-1:0]      WMWAR;
  logic [DW-1:0]      WMWDR;
  logic               WMWE;

  wm_access_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .flush(flush), .flush_done(flush_done),
    .WMAR(WMAR), .WMDR(WMDR), .WMWAR(WMWAR), .WMWDR(WMWDR), .WMWE(WMWE)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Addresses 0..7 start with a recognisable pattern, everything else is 0.
  function automatic logic [DW-1:0] seedValue(input logic [AW-1:0] a);
    if (a < AW'(8)) begin
      return {4{32'hC0DE_0000 + 32'(a) * 32'h0001_1001}};
    end
    return '0;
  endfunction

  // Behavioural WM: read data one cycle after WMAR, read-before-write.
  bit [DW-1:0] ram [0:8191];
  bit          ramWritten [0:8191];
  always @(posedge clock) begin
    if (WMWE === 1'b1) begin
      ram[WMWAR]        <= WMWDR;
      ramWritten[WMWAR] <= 1'b1;
    end
    WMDR <= ramWritten[WMAR] ? ram[WMAR] : seedValue(WMAR);
  end

  int checks;
  int errors;
  int cycle;

  // Stimulus held between cycles, one entry per requester.
  logic [NREQ-1:0] sv;
  logic [NREQ-1:0] swe;
  logic [AW-1:0]   sa [NREQ];
  logic [DW-1:0]   sd [NREQ];

  // Reference model.
  typedef struct {
    int          due;
    int          idx;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } pend_t;

  pend_t         pendQ[$];
  logic [DW-1:0] mMem [0:8191];
  int            mPtr;
  int            mMode;
  bit            mKnown;
  bit            mPrevWr;
  logic [AW-1:0] mPrevWrAddr;
  logic [DW-1:0] mPrevWrData;
  bit            mPrevRd;
  logic [AW-1:0] mPrevRdAddr;
  logic [DW-1:0] mLast;
  int            mLastGrant;

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cycle, observed, expected);
    end
  endtask

  function automatic logic [DW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Compare this cycle's outputs with the model, then advance the model by
  // the grant it expects in this cycle.
  task automatic stepModel();
    logic [NREQ-1:0] expReady;
    logic [NREQ-1:0] expRv;
    logic [DW-1:0]   expRd;
    logic [AW-1:0]   a;
    logic [DW-1:0]   d;
    pend_t           e;
    int              grant;

    if (mKnown) begin
      expRv = '0;
      expRd = mLast;
      if (pendQ.size() > 0 && pendQ[0].due == cycle) begin
        expRv[pendQ[0].idx] = 1'b1;
        expRd = pendQ[0].data;
        mLast = pendQ[0].data;
        void'(pendQ.pop_front());
      end
      checkOutput("rsp_valid", DW'(rsp_valid), DW'(expRv));
      checkOutput("rsp_data", rsp_data, expRd);
      checkOutput("WMWE", DW'(WMWE), DW'(mPrevWr));
      if (mPrevWr) begin
        checkOutput("WMWAR", DW'(WMWAR), DW'(mPrevWrAddr));
        checkOutput("WMWDR", WMWDR, mPrevWrData);
      end
      if (mPrevRd) begin
        checkOutput("WMAR", DW'(WMAR), DW'(mPrevRdAddr));
      end
      checkOutput("flush_done", DW'(flush_done), DW'(mMode == 2));
    end

    grant = -1;
    expReady = '0;
    if (mKnown && reset && mMode == 0 && !flush) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (mPtr + k) % NREQ;
        if (grant < 0 && req_valid[j]) grant = j;
      end
    end
    if (grant >= 0) expReady[grant] = 1'b1;
    if (mKnown || !reset) begin
      checkOutput("req_ready", DW'(req_ready), DW'(expReady));
    end

    mLastGrant = grant;
    if (!reset) begin
      pendQ.delete();
      mPtr    = 0;
      mMode   = 0;
      mPrevWr = 1'b0;
      mPrevRd = 1'b0;
      mLast   = '0;
      mKnown  = 1'b1;
    end else if (mKnown) begin
      mPrevWr = 1'b0;
      mPrevRd = 1'b0;
      if (grant >= 0) begin
        mPtr = (grant + 1) % NREQ;
        a = req_addr[grant*AW +: AW];
        d = req_wdata[grant*DW +: DW];
        if (req_we[grant]) begin
          mPrevWr     = 1'b1;
          mPrevWrAddr = a;
          mPrevWrData = d;
          mMem[a]     = d;
`ifdef WM_RAW_BYPASS_EN
          for (int k = 0; k < pendQ.size(); k++) begin
            if (pendQ[k].addr == a) begin
              e = pendQ[k];
              e.data = d;
              pendQ[k] = e;
            end
          end
`endif
        end else begin
          mPrevRd     = 1'b1;
          mPrevRdAddr = a;
          e.due  = cycle + RD_LAT + 1;
          e.idx  = grant;
          e.addr = a;
          e.data = mMem[a];
          pendQ.push_back(e);
        end
      end
      case (mMode)
        0: if (flush) mMode = 1;
        1: if (pendQ.size() == 0) mMode = flush ? 2 : 0;
        default: if (!flush) mMode = 0;
      endcase
    end
    cycle++;
  endtask

  // One clock cycle: drive held stimulus just after the rising edge, check
  // on the falling edge.
  task automatic applyStimulus(input logic fl, input logic rs);
    @(posedge clock);
    #1;
    reset = rs;
    flush = fl;
    req_valid = sv;
    req_we = swe;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW]  = sa[i];
      req_wdata[i*DW +: DW] = sd[i];
    end
    @(negedge clock);
    stepModel();
  endtask

  task automatic setReq(input int i, input logic v, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    sv[i]  = v;
    swe[i] = we;
    sa[i]  = a;
    sd[i]  = d;
  endtask

  task automatic idleAll();
    for (int i = 0; i < NREQ; i++) setReq(i, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic fl;
    checks = 0;
    errors = 0;
    cycle = 0;
    mKnown = 1'b0;
    mPtr = 0;
    mMode = 0;
    mPrevWr = 1'b0;
    mPrevRd = 1'b0;
    mLast = '0;
    mLastGrant = -1;
    for (int i = 0; i < 8192; i++) mMem[i] = seedValue(AW'(i));
    reset = 1'b0;
    flush = 1'b0;
    req_valid = '0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;

    // Reset held with every requester asking to read.
    for (int i = 0; i < NREQ; i++) setReq(i, 1'b1, 1'b0, AW'(i), '0);
    for (int n = 0; n < 3; n++) applyStimulus(1'b0, 1'b0);

    // Continuous reads from all three: rotation 0,1,2 and tagged returns.
    for (int n = 0; n < 12; n++) begin
      if (mLastGrant >= 0) sa[mLastGrant] = AW'($urandom_range(0, 7));
      applyStimulus(1'b0, 1'b1);
    end
    idleAll();
    for (int n = 0; n < 4; n++) applyStimulus(1'b0, 1'b1);

    // Write addr 5 from requester 1, then read it back from requester 0.
    setReq(1, 1'b1, 1'b1, AW'(5), 128'hA5);
    applyStimulus(1'b0, 1'b1);
    idleAll();
    setReq(0, 1'b1, 1'b0, AW'(5), '0);
    applyStimulus(1'b0, 1'b1);
    idleAll();
    for (int n = 0; n < 4; n++) applyStimulus(1'b0, 1'b1);

    // Flush with two reads in flight, then release and resume.
    setReq(0, 1'b1, 1'b0, AW'(1), '0);
    applyStimulus(1'b0, 1'b1);
    idleAll();
    setReq(2, 1'b1, 1'b0, AW'(2), '0);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < NREQ; i++) setReq(i, 1'b1, 1'b0, AW'(i + 3), '0);
    for (int n = 0; n < 7; n++) applyStimulus(1'b1, 1'b1);
    for (int n = 0; n < 4; n++) applyStimulus(1'b0, 1'b1);
    idleAll();
    for (int n = 0; n < 4; n++) applyStimulus(1'b0, 1'b1);

    // Reset with two reads in flight: no strobes, requester 0 first after.
    setReq(1, 1'b1, 1'b0, AW'(6), '0);
    applyStimulus(1'b0, 1'b1);
    idleAll();
    setReq(2, 1'b1, 1'b0, AW'(7), '0);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < NREQ; i++) setReq(i, 1'b1, 1'b0, AW'(i), '0);
    applyStimulus(1'b0, 1'b0);
    for (int n = 0; n < 5; n++) applyStimulus(1'b0, 1'b1);
    idleAll();
    for (int n = 0; n < 4; n++) applyStimulus(1'b0, 1'b1);

    // Read addr 9 immediately followed by a write of 128'h77 to addr 9.
    setReq(0, 1'b1, 1'b0, AW'(9), '0);
    applyStimulus(1'b0, 1'b1);
    idleAll();
    setReq(1, 1'b1, 1'b1, AW'(9), 128'h77);
    applyStimulus(1'b0, 1'b1);
    idleAll();
    for (int n = 0; n < 4; n++) applyStimulus(1'b0, 1'b1);

    // Random traffic with occasional flush and reset.
    fl = 1'b0;
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(sv[i] && mLastGrant != i && $urandom_range(0, 3) != 0)) begin
          setReq(i, ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 7)), rand128());
        end
      end
      if ($urandom_range(0, 29) == 0) fl = ~fl;
      applyStimulus(fl, ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1);
    end
    idleAll();
    for (int n = 0; n < 6; n++) applyStimulus(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
